multicycle_ctrl_fsm: RTL and testbench

- Main sequencing FSM for the multicycle ARM-subset core with FPU extension.
- Decodes Op/Funct, then steps the shared datapath through fetch, decode, execute, memory and writeback states.
- Drives the mux selects and the unconditional write enables (NextPC, RegW, MemW, FPUW) consumed by the condition logic.
- Adds a start/done handshake to the multi-cycle FPU, with a timeout watchdog.

---
 rtl/multicycle_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main sequencing FSM for the multicycle ARM-subset core with FPU extension.
// It decodes Op/Funct and steps the shared datapath through the fetch, decode,
// execute, memory and writeback states. It drives the datapath mux selects and
// the unconditional write requests (NextPC, RegW, MemW, FPUW) that the
// condition logic qualifies. It also handshakes with the multi-cycle FPU
// (FPUStart / FPUDone) and runs a timeout watchdog while the FPU is busy.
//
// Parameters
//   FPU_TIMEOUT : maximum cycles spent in FPUWAIT before abort (1..255)
//   CNT_W       : width of the FPU wait counter, 2**CNT_W > FPU_TIMEOUT
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   Op[1:0]    in   instruction class: 00 data-proc, 01 memory, 10 branch,
//                   11 FPU
//   Funct[5:0] in   [5] immediate operand, [0] load (memory class)
//   FPUDone    in   FPU result valid, only looked at in FPUWAIT
//   IRWrite    out  instruction register load
//   AdrSrc     out  memory address select: 0 PC, 1 ALU result
//   ALUSrcA    out  0 register A, 1 PC
//   ALUSrcB    out  00 reg, 01 imm, 10 const 4
//   ResultSrc  out  00 ALUOut, 01 data, 10 ALU direct
//   ALUOp      out  ALU decoder uses Funct when 1, otherwise add
//   NextPC     out  PC update request
//   RegW       out  register write request (pre-condition)
//   MemW       out  memory write request (pre-condition)
//   FPUW       out  FPU result write request (pre-condition)
//   Branch     out  conditional branch request
//   FPUStart   out  one-cycle FPU issue pulse
//   FPUErr     out  sticky FPU timeout flag, cleared only by reset
//   State[3:0] out  current state encoding
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned FPU_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       FPUW,
  output logic       Branch,
  output logic       FPUStart,
  output logic       FPUErr,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FPUISSUE = 4'd10,
    FPUWAIT  = 4'd11,
    FPUWB    = 4'd12
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       fpuw;
    logic       branch;
    logic       fpustart;
  } ctrl_t;

  // Last counter value that still counts as a wait cycle; reaching it with no
  // FPUDone means FPU_TIMEOUT wait cycles have elapsed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             err_n;
  ctrl_t            ctl;

  // Funct[4:1] belong to the ALU decoder, not to sequencing.
  logic unused_funct;
  assign unused_funct = &{1'b0, Funct[4:1]};

  // Moore output table, indexed by state. Illegal codes produce all zeros.
  function automatic ctrl_t decode_ctl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      MEMADR:   c.alusrcb = 2'b01;
      MEMRD:    c.adrsrc  = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regw      = 1'b1;
      end
      MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      EXECUTER: c.aluop = 1'b1;
      EXECUTEI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 1'b1;
      end
      ALUWB:    c.regw = 1'b1;
      BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.branch    = 1'b1;
      end
      FPUISSUE: c.fpustart = 1'b1;
      FPUWB:    c.fpuw     = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state, wait counter and sticky error logic.
  always_comb begin
    state_n = FETCH;
    cnt_n   = cnt;
    err_n   = FPUErr;
    case (state)
      FETCH:  state_n = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_n = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = FPUISSUE;
        endcase
      end
      MEMADR:   state_n = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_n = MEMWB;
      EXECUTER,
      EXECUTEI: state_n = ALUWB;
      FPUISSUE: begin
        state_n = FPUWAIT;
        cnt_n   = '0;
      end
      FPUWAIT: begin
        // FPUDone takes priority over an expiring watchdog.
        if (FPUDone) begin
          state_n = FPUWB;
        end else if (cnt == CNT_LAST) begin
          state_n = FETCH;
          err_n   = 1'b1;
        end else begin
          state_n = FPUWAIT;
          cnt_n   = cnt + 1'b1;
        end
      end
      // Writeback states, BRANCH and illegal codes all return to FETCH.
      default:  state_n = FETCH;
    endcase
  end

  // Outputs are registered from the next state, so they line up with State
  // exactly as combinational Moore decoding would, but without decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      cnt    <= '0;
      FPUErr <= 1'b0;
      ctl    <= decode_ctl(FETCH);
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      FPUErr <= err_n;
      ctl    <= decode_ctl(state_n);
    end
  end

  assign State     = state;
  assign IRWrite   = ctl.irwrite;
  assign AdrSrc    = ctl.adrsrc;
  assign ALUSrcA   = ctl.alusrca;
  assign ALUSrcB   = ctl.alusrcb;
  assign ResultSrc = ctl.resultsrc;
  assign ALUOp     = ctl.aluop;
  assign NextPC    = ctl.nextpc;
  assign RegW      = ctl.regw;
  assign MemW      = ctl.memw;
  assign FPUW      = ctl.fpuw;
  assign Branch    = ctl.branch;
  assign FPUStart  = ctl.fpustart;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Directed testbench for multicycle_ctrl_fsm. Each cycle it compares State,
// the full control-output vector (against a hand-written per-state table) and
// FPUErr.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FPUDone;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       FPUW;
  logic       Branch;
  logic       FPUStart;
  logic       FPUErr;
  logic [3:0] State;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        exp_err;

  multicycle_ctrl_fsm #(
    .FPU_TIMEOUT(16),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Op(Op),
    .Funct(Funct),
    .FPUDone(FPUDone),
    .IRWrite(IRWrite),
    .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc),
    .ALUOp(ALUOp),
    .NextPC(NextPC),
    .RegW(RegW),
    .MemW(MemW),
    .FPUW(FPUW),
    .Branch(Branch),
    .FPUStart(FPUStart),
    .FPUErr(FPUErr),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,FPUW,Branch,FPUStart}
  logic [13:0] obs_out;
  assign obs_out = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                    NextPC, RegW, MemW, FPUW, Branch, FPUStart};

  function automatic logic [13:0] exp_out(input logic [3:0] s);
    case (s)
      4'd0:    return 14'b1_0_1_10_10_0_1_0_0_0_0_0;
      4'd1:    return 14'b0_0_1_10_10_0_0_0_0_0_0_0;
      4'd2:    return 14'b0_0_0_01_00_0_0_0_0_0_0_0;
      4'd3:    return 14'b0_1_0_00_00_0_0_0_0_0_0_0;
      4'd4:    return 14'b0_0_0_00_01_0_0_1_0_0_0_0;
      4'd5:    return 14'b0_1_0_00_00_0_0_0_1_0_0_0;
      4'd6:    return 14'b0_0_0_00_00_1_0_0_0_0_0_0;
      4'd7:    return 14'b0_0_0_01_00_1_0_0_0_0_0_0;
      4'd8:    return 14'b0_0_0_00_00_0_0_1_0_0_0_0;
      4'd9:    return 14'b0_0_0_01_10_0_0_0_0_0_1_0;
      4'd10:   return 14'b0_0_0_00_00_0_0_0_0_0_0_1;
      4'd11:   return 14'b0_0_0_00_00_0_0_0_0_0_0_0;
      4'd12:   return 14'b0_0_0_00_00_0_0_0_0_1_0_0;
      default: return 14'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle against state s, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] s);
    check({tag, ".st"},  32'(State),   32'(s));
    check({tag, ".out"}, 32'(obs_out), 32'(exp_out(s)));
    check({tag, ".err"}, 32'(FPUErr),  32'(exp_err));
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_err  = 1'b0;
    reset    = 1'b1;
    Op       = 2'b00;
    Funct    = 6'b0;
    FPUDone  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Data-processing immediate: 0,1,7,8
    Op = 2'b00; Funct = 6'b100000;
    cyc("dpi0", 0); cyc("dpi1", 1); cyc("dpi7", 7); cyc("dpi8", 8);

    // Data-processing register, FPUDone held high must be ignored.
    Op = 2'b00; Funct = 6'b000000; FPUDone = 1'b1;
    cyc("dpr0", 0); cyc("dpr1", 1); cyc("dpr6", 6); cyc("dpr8", 8);
    FPUDone = 1'b0;

    // Load: 0,1,2,3,4
    Op = 2'b01; Funct = 6'b000001;
    cyc("ld0", 0); cyc("ld1", 1); cyc("ld2", 2); cyc("ld3", 3); cyc("ld4", 4);

    // Store: 0,1,2,5
    Op = 2'b01; Funct = 6'b000000;
    cyc("st0", 0); cyc("st1", 1); cyc("st2", 2); cyc("st5", 5);

    // Branch: 0,1,9
    Op = 2'b10; Funct = 6'b0;
    cyc("br0", 0); cyc("br1", 1); cyc("br9", 9);

    // FPU, done on the third wait cycle.
    Op = 2'b11;
    cyc("fd0", 0); cyc("fd1", 1); cyc("fd10", 10);
    cyc("fdw1", 11); cyc("fdw2", 11);
    FPUDone = 1'b1;
    cyc("fdw3", 11);
    FPUDone = 1'b0;
    cyc("fd12", 12);

    // FPU timeout: exactly 16 wait cycles, then FETCH with FPUErr set.
    Op = 2'b11;
    cyc("to0", 0); cyc("to1", 1); cyc("to10", 10);
    for (int i = 0; i < 16; i++) cyc($sformatf("tow%0d", i + 1), 11);
    exp_err = 1'b1;

    // FPUErr stays set across a later branch.
    Op = 2'b10;
    cyc("sb0", 0); cyc("sb1", 1); cyc("sb9", 9);

    // Reset in the middle of FPUWAIT clears state and FPUErr.
    Op = 2'b11;
    cyc("rf0", 0); cyc("rf1", 1); cyc("rf10", 10); cyc("rfw1", 11);
    check("rfw2.st", 32'(State), 32'd11);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_err = 1'b0;
    Op      = 2'b10;
    cyc("rf_after", 0); cyc("rf_b1", 1); cyc("rf_b9", 9);

    // FPUDone arriving on the 16th (last) wait cycle wins over the timeout.
    Op = 2'b11;
    cyc("v0", 0); cyc("v1", 1); cyc("v10", 10);
    for (int i = 0; i < 15; i++) cyc($sformatf("vw%0d", i + 1), 11);
    FPUDone = 1'b1;
    cyc("vw16", 11);
    FPUDone = 1'b0;
    cyc("v12", 12);

    // Reset while in MEMWR: no further MemW after the reset edge.
    Op = 2'b01; Funct = 6'b000000;
    cyc("rm0", 0); cyc("rm1", 1); cyc("rm2", 2);
    check("rm5.st", 32'(State), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Op = 2'b10;
    cyc("rm_after", 0); cyc("rm_b1", 1); cyc("rm_b9", 9);
    cyc("end0", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
